// File: rtl/game_tick_divider_if.sv
// game_tick_divider_if
//   Carries the game-update strobe and the pulse counter from the divider
//   to its consumers (game FSM, debug/scoring logic).
//
//   game_tick   1      one-cycle pulse per divider period
//   tick_count  CNT_W  pulses seen since reset, wraps modulo 2^CNT_W
//
//   master : the divider, drives both signals
//   slave  : any consumer, reads both signals
interface game_tick_divider_if #(
  parameter int CNT_W = 16
);
  logic             game_tick;
  logic [CNT_W-1:0] tick_count;

  modport master (output game_tick, output tick_count);
  modport slave  (input  game_tick, input  tick_count);
endinterface

// File: rtl/game_tick_divider.sv
// game_tick_divider
//   Divides the system clock down to the game update rate and emits a
//   registered single-cycle strobe once every DIVISOR cycles, together with
//   a free-running count of strobes since reset.
//
//   clk      in   system clock, rising-edge active
//   reset    in   asynchronous reset, active-low
//   tick_if  master modport: game_tick (1b), tick_count (CNT_W bits)
//
//   DIVISOR = CLK_FREQ / TICKS_PER_SEC (truncated; the small rate error of a
//   non-integer ratio is accepted, there is no fractional accumulation).
module game_tick_divider #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int TICKS_PER_SEC = 10,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  game_tick_divider_if.master  tick_if
);

  // Guarded so a zero rate reaches the fatal check below rather than a
  // divide-by-zero during parameter evaluation.
  localparam int DIVISOR = (TICKS_PER_SEC > 0) ? (CLK_FREQ / TICKS_PER_SEC) : 0;
  localparam int DIV_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);

  generate
    if (TICKS_PER_SEC <= 0 || DIVISOR < 1) begin : g_bad_divisor
      $fatal(1, "game_tick_divider: TICKS_PER_SEC must be > 0 and give DIVISOR >= 1");
    end
    if (TICKS_PER_SEC > CLK_FREQ) begin : g_bad_rate
      $fatal(1, "game_tick_divider: TICKS_PER_SEC exceeds CLK_FREQ");
    end
  endgenerate

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_game_tick;
  logic [CNT_W-1:0] r_tick_count;
  logic             w_wrap;

  // With DIVISOR == 1 this is always true, so the strobe sits high on every
  // cycle after the first edge out of reset.
  assign w_wrap = (r_div_cnt == DIV_LAST);

  // A reset mid-period discards the phase: the next strobe is a full
  // DIVISOR edges after release, never early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt    <= '0;
      r_game_tick  <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_div_cnt   <= w_wrap ? '0 : r_div_cnt + 1'b1;
      r_game_tick <= w_wrap;
      if (w_wrap) begin
        r_tick_count <= r_tick_count + 1'b1;
      end
    end
  end

  assign tick_if.game_tick  = r_game_tick;
  assign tick_if.tick_count = r_tick_count;

endmodule

// File: tb/tb_game_tick_divider.sv
// tb_game_tick_divider
//   Four divider instances share one clock and one active-low reset:
//     a : CLK_FREQ=50, TICKS_PER_SEC=10          -> DIVISOR 5,  CNT_W 16
//     b : CLK_FREQ=10, TICKS_PER_SEC=10          -> DIVISOR 1,  CNT_W 16
//     c : CLK_FREQ=20, TICKS_PER_SEC=10, CNT_W=3 -> DIVISOR 2,  wraps at 8
//     d : default parameters                     -> DIVISOR 5_000_000
//   After the k-th edge following release an instance with divisor D must
//   show game_tick = (k % D == 0) and tick_count = (k / D) mod 2^CNT_W.
module tb_game_tick_divider;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;

  game_tick_divider_if #(.CNT_W(16)) if_a ();
  game_tick_divider_if #(.CNT_W(16)) if_b ();
  game_tick_divider_if #(.CNT_W(3))  if_c ();
  game_tick_divider_if #(.CNT_W(16)) if_d ();

  game_tick_divider #(.CLK_FREQ(50), .TICKS_PER_SEC(10), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(rst_n), .tick_if(if_a)
  );
  game_tick_divider #(.CLK_FREQ(10), .TICKS_PER_SEC(10), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(rst_n), .tick_if(if_b)
  );
  game_tick_divider #(.CLK_FREQ(20), .TICKS_PER_SEC(10), .CNT_W(3)) u_dut_c (
    .clk(clk), .reset(rst_n), .tick_if(if_c)
  );
  game_tick_divider u_dut_d (
    .clk(clk), .reset(rst_n), .tick_if(if_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a.tick"},  32'(if_a.game_tick),  32'd0);
    check({tag, " a.count"}, 32'(if_a.tick_count), 32'd0);
    check({tag, " b.tick"},  32'(if_b.game_tick),  32'd0);
    check({tag, " b.count"}, 32'(if_b.tick_count), 32'd0);
    check({tag, " c.tick"},  32'(if_c.game_tick),  32'd0);
    check({tag, " c.count"}, 32'(if_c.tick_count), 32'd0);
    check({tag, " d.tick"},  32'(if_d.game_tick),  32'd0);
    check({tag, " d.count"}, 32'(if_d.tick_count), 32'd0);
  endtask

  // Runs n edges after a release at a negedge, checking every instance
  // against the closed-form expectation. Records c's count at each of its
  // pulses into c_seq.
  logic [2:0] c_seq [0:19];

  task automatic run_after_release(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      check({tag, " a.tick"},  32'(if_a.game_tick),  32'((k % 5) == 0));
      check({tag, " a.count"}, 32'(if_a.tick_count), 32'(k / 5));
      check({tag, " b.tick"},  32'(if_b.game_tick),  32'd1);
      check({tag, " b.count"}, 32'(if_b.tick_count), 32'(k));
      check({tag, " c.tick"},  32'(if_c.game_tick),  32'((k % 2) == 0));
      check({tag, " c.count"}, 32'(if_c.tick_count), 32'((k / 2) % 8));
      check({tag, " d.tick"},  32'(if_d.game_tick),  32'd0);
      check({tag, " d.count"}, 32'(if_d.tick_count), 32'd0);
      if ((k % 2) == 0 && (k / 2) <= 20) c_seq[k/2 - 1] = if_c.tick_count;
    end
  endtask

  logic [2:0] wrap_exp [0:8];

  initial begin
    wrap_exp[0] = 3'd1; wrap_exp[1] = 3'd2; wrap_exp[2] = 3'd3;
    wrap_exp[3] = 3'd4; wrap_exp[4] = 3'd5; wrap_exp[5] = 3'd6;
    wrap_exp[6] = 3'd7; wrap_exp[7] = 3'd0; wrap_exp[8] = 3'd1;
    for (int i = 0; i < 20; i++) c_seq[i] = 3'd0;

    // Reset held with the clock running.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("reset_hold");
    end

    // Release between edges; 40 edges cover 8 periods of a and 20 of c.
    @(negedge clk);
    rst_n = 1'b1;
    run_after_release(40, "run1");

    for (int i = 0; i < 9; i++) begin
      check($sformatf("c_wrap_seq[%0d]", i), 32'(c_seq[i]), 32'(wrap_exp[i]));
    end

    // Three edges into a's ninth period, then an asynchronous reset
    // between edges: outputs must clear before the next edge.
    for (int k = 41; k <= 43; k++) begin
      @(posedge clk);
      #1;
      check("pre_mid_reset a.tick",  32'(if_a.game_tick),  32'd0);
      check("pre_mid_reset a.count", 32'(if_a.tick_count), 32'd8);
      check("pre_mid_reset b.tick",  32'(if_b.game_tick),  32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_clear");
    @(posedge clk);
    #1;
    check_all_zero("mid_reset_hold");

    // After release, a must wait a full 5 edges and restart its count at 0.
    @(negedge clk);
    rst_n = 1'b1;
    run_after_release(12, "run2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
